// File: rtl/sd_block_responder.sv
// sd_block_responder: serves 256-word sectors between a client buffer and a word-addressed backing store.
// Optional feature: define SD_RESP_WRPROT_EN to add the wr_protect input that blocks sector writes.
module sd_block_responder #(
    parameter int LBA_BITS = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
`ifdef SD_RESP_WRPROT_EN
    input  logic                  wr_protect,
`endif
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_din,
    output logic [LBA_BITS+7:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [15:0]           mem_din,
    input  logic [15:0]           mem_dout,
    input  logic                  mem_ready,
    output logic                  lba_err
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_CAP, WR_REQ, DONE} state_t;
    state_t                state_q, state_d;
    logic [7:0]            idx_q, idx_d;
    logic [LBA_BITS-1:0]   lba_q, lba_d;
    logic                  oor_q, oor_d;
    logic                  prot_q, prot_d;
    logic [15:0]           dout_q, dout_d;
    logic [15:0]           din_q, din_d;
    logic                  prot_in;
    logic                  blk;
`ifdef SD_RESP_WRPROT_EN
    assign prot_in = wr_protect;
`else
    assign prot_in = 1'b0;
`endif
    // a blocked transfer never touches memory but keeps the normal cadence
    assign blk          = oor_q | prot_q;
    assign sd_ack       = state_q != IDLE && state_q != DONE;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = dout_q;
    assign mem_din      = din_q;
    assign mem_addr     = {lba_q, idx_q};
    assign lba_err      = state_q == DONE && blk;
    // next-state, datapath updates and request strobes
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lba_d      = lba_q;
        oor_d      = oor_q;
        prot_d     = prot_q;
        dout_d     = dout_q;
        din_d      = din_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        case (state_q)
            IDLE: if (sd_rd || sd_wr) begin
                state_d = sd_rd ? RD_REQ : WR_ADDR;
                lba_d   = sd_lba[LBA_BITS-1:0];
                oor_d   = |(sd_lba >> LBA_BITS);
                prot_d  = !sd_rd && prot_in;
                idx_d   = '0;
            end
            RD_REQ: begin
                mem_rd = !blk;
                if (blk || mem_ready) begin
                    dout_d  = blk ? 16'hFFFF : mem_dout;
                    state_d = RD_PUT;
                end
            end
            RD_PUT: begin
                sd_buff_wr = 1'b1;
                state_d    = idx_q == 8'hFF ? DONE : RD_REQ;
                idx_d      = idx_q == 8'hFF ? idx_q : idx_q + 8'd1;
            end
            WR_ADDR: state_d = WR_CAP;
            WR_CAP: begin
                din_d   = sd_buff_din;
                state_d = WR_REQ;
            end
            WR_REQ: begin
                mem_wr = !blk;
                if (blk || mem_ready) begin
                    state_d = idx_q == 8'hFF ? DONE : WR_ADDR;
                    idx_d   = idx_q == 8'hFF ? idx_q : idx_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lba_q   <= '0;
            oor_q   <= 1'b0;
            prot_q  <= 1'b0;
            dout_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lba_q   <= lba_d;
            oor_q   <= oor_d;
            prot_q  <= prot_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
        end
    end
endmodule

// File: tb/tb_sd_block_responder.sv
// tb_sd_block_responder: randomized sector transfers checked against a queue-based reference model.
module tb_sd_block_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic        sd_rd = 1'b0, sd_wr = 1'b0;
    logic        sd_ack, sd_buff_wr, mem_rd, mem_wr, lba_err;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout, sd_buff_din = '0, mem_din, mem_dout;
    logic [11:0] mem_addr;
    logic        mem_ready = 1'b0;
`ifdef SD_RESP_WRPROT_EN
    logic        wr_protect = 1'b0;
`endif

    sd_block_responder #(.LBA_BITS(4)) dut (
        .clk_sys(clk), .reset_n(reset_n),
`ifdef SD_RESP_WRPROT_EN
        .wr_protect(wr_protect),
`endif
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
        .sd_buff_din(sd_buff_din), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready), .lba_err(lba_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [15:0] mem [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic [15:0] client [0:255];
    logic [23:0] exp_strobe [$];
    logic [27:0] exp_wr [$];
    logic [3:0]  cur_lba;
    bit          cur_oor, ready_mode, ack_prev;
    int          strobes, wr_done, err_seen, ack_rises;
    logic [23:0] first_s, last_s;
    logic [11:0] first_ma;
    logic [7:0]  a_s;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_wr && mem_ready) mem[mem_addr] <= mem_din;
    always @(posedge clk) begin
        #1;
        mem_ready = ready_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
    end
    always @(negedge clk) a_s = sd_buff_addr;
    always @(posedge clk) begin
        #1;
        sd_buff_din = client[a_s];
    end

    always @(negedge clk) if (reset_n) begin
        if (sd_buff_wr) begin
            if (exp_strobe.size() == 0) begin
                checks++; errors++;
                $display("FAIL strobe_extra: got addr %0h dout %0h expected no strobe", sd_buff_addr, sd_buff_dout);
            end else chk("strobe", {sd_buff_addr, sd_buff_dout}, exp_strobe.pop_front());
            if (strobes == 0) first_s = {sd_buff_addr, sd_buff_dout};
            last_s = {sd_buff_addr, sd_buff_dout};
            strobes++;
        end
        if (mem_rd && mem_ready) begin
            if (strobes == 0) first_ma = mem_addr;
            chk("mem_rd_addr", {cur_oor, mem_addr}, {1'b0, cur_lba, 8'(strobes)});
        end
        if (mem_wr && mem_ready) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_wr_extra: got addr %0h data %0h expected no write", mem_addr, mem_din);
            end else begin
                logic [27:0] e;
                e = exp_wr.pop_front();
                chk("mem_wr", {mem_addr, mem_din}, e);
                ref_mem[e[27:16]] = e[15:0];
            end
            wr_done++;
        end
        if (lba_err) err_seen++;
        if (sd_ack && !ack_prev) ack_rises++;
        ack_prev = sd_ack;
    end

    task automatic check_mem(input string name);
        int bad = 0;
        for (int a = 0; a < 4096; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk(name, bad, 0);
    endtask

    task automatic check_idle_zero(input string name);
        chk(name, {sd_ack, sd_buff_wr, mem_rd, mem_wr, lba_err, sd_buff_addr, sd_buff_dout, mem_addr, mem_din}, 0);
    endtask

    task automatic start(input bit rd, input bit wr, input logic [31:0] lba, input bit prot, input bit rmode);
        int to;
        cur_lba = lba[3:0]; cur_oor = lba >= 16;
        strobes = 0; wr_done = 0; err_seen = 0; ack_rises = 0;
        @(posedge clk); #1;
        ready_mode = rmode; sd_lba = lba; sd_rd = rd; sd_wr = wr;
`ifdef SD_RESP_WRPROT_EN
        wr_protect = prot;
`endif
        for (to = 0; to < 4 && !sd_ack; to++) @(negedge clk);
        chk("ack_rise", sd_ack, 1);
        sd_rd = 1'b0; sd_wr = 1'b0; sd_lba = $urandom;
    endtask

    task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] lba, input bit prot, input bit rmode, input bit rnd);
        bit is_rd, oor, eff_prot, blk;
        int to;
        is_rd = rd; oor = lba >= 16;
`ifdef SD_RESP_WRPROT_EN
        eff_prot = prot;
`else
        eff_prot = 1'b0;
`endif
        blk = !is_rd && (oor || eff_prot);
        for (int i = 0; i < 256; i++) begin
            client[i] = rnd ? 16'($urandom) : ~16'(i);
            if (is_rd) exp_strobe.push_back({8'(i), oor ? 16'hFFFF : ref_mem[{lba[3:0], 8'(i)}]});
            else if (!blk) exp_wr.push_back({lba[3:0], 8'(i), client[i]});
        end
        start(rd, wr, lba, prot, rmode);
        for (to = 0; to < 6000 && sd_ack; to++) @(negedge clk);
        chk("ack_fall", sd_ack, 0);
        @(negedge clk);
        chk("strobe_count", strobes, is_rd ? 256 : 0);
        chk("wr_count", wr_done, (is_rd || blk) ? 0 : 256);
        chk("queues_empty", exp_strobe.size() + exp_wr.size(), 0);
        chk("lba_err_count", err_seen, (oor || (!is_rd && eff_prot)) ? 1 : 0);
        chk("ack_single_span", ack_rises, 1);
        chk("idle_after", {sd_ack, lba_err}, 0);
    endtask

    initial begin
        int to;
        for (int a = 0; a < 4096; a++) begin
            mem[a] = 16'(a % 256);
            ref_mem[a] = 16'(a % 256);
        end
        for (int i = 0; i < 256; i++) client[i] = '0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset_outputs");
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check_idle_zero("idle_outputs");

        do_xfer(1, 0, 3, 0, 0, 0);
        chk("read3_first", first_s, 24'h000000);
        chk("read3_last", last_s, 24'hFF00FF);
        chk("read3_first_mem_addr", first_ma, 12'h300);

        do_xfer(0, 1, 15, 0, 1, 0);
        check_mem("mem_after_wr15");
        chk("mem_F05", mem[12'hF05], 16'hFFFA);

        do_xfer(1, 0, 16, 0, 1, 0);
        chk("oor_last", last_s, 24'hFFFFFF);

        do_xfer(1, 1, 0, 0, 0, 0);
        do_xfer(0, 1, 32'h1234_0007, 0, 0, 1);
        check_mem("mem_after_oor_wr");

        for (int i = 0; i < 256; i++) begin
            client[i] = 16'($urandom);
            exp_wr.push_back({4'd5, 8'(i), client[i]});
        end
        start(0, 1, 5, 0, 1);
        for (to = 0; to < 5000 && wr_done < 100; to++) @(negedge clk);
        chk("rst_reach_word100", wr_done, 100);
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        check_idle_zero("rst_mid_outputs");
        exp_wr.delete();
        @(posedge clk); #1 reset_n = 1'b1; ready_mode = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_no_wr_after", wr_done, 100);
        check_mem("mem_after_abort");
        do_xfer(1, 0, 5, 0, 1, 0);

        do_xfer(0, 1, 2, 1, 1, 0);
        check_mem("mem_after_prot");
`ifdef SD_RESP_WRPROT_EN
        chk("prot_word", mem[12'h210], 16'h0010);
`else
        chk("prot_word", mem[12'h210], 16'hFFEF);
`endif

        for (int k = 0; k < 4; k++) begin
            bit r;
            r = 1'($urandom);
            do_xfer(r, !r, 32'($urandom_range(0, 19)), 1'($urandom), 1'($urandom), 1);
            check_mem("mem_after_random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
